divider_seq: RTL and testbench

- Multi-cycle restoring integer divider for the gate-level ALU. It is the inverse-direction companion of the ripple adder path: division is done by repeated trial subtraction.
- Takes dividend and divisor on a start strobe and computes one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done pulse.
- Sits beside the adder/ALU datapath as the ALU's DIV/MOD resource.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_sub_step.sv | 36 +++
 rtl/divider_seq.sv | 181 ++++++++++++++++++
 tb/tb_divider_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e         : controller state encoding (idle / iterate / result stage)
//   DivWidthDefault     : default operand width
//   div_cnt_width()     : width of the step counter for a given operand width
//   DivCntWidthDefault  : step counter width at the default operand width
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam int unsigned DivWidthDefault = 4;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DivCntWidthDefault = div_cnt_width(DivWidthDefault);

endpackage

// File: rtl/div_sub_step.sv
// Combinational (WIDTH+1)-bit trial subtractor for one restoring-division step.
// Computes trial - {0, divisor} as trial + ~{0, divisor} + 1 through a full-adder
// ripple chain.
//   trial   in  WIDTH+1  partial remainder shifted with the next dividend bit
//   divisor in  WIDTH    divisor
//   diff    out WIDTH+1  difference
//   borrow  out 1        high when divisor > trial (inverted carry-out)
module div_sub_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidthDefault
) (
  input  logic [WIDTH:0]   trial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   diff,
  output logic             borrow
);

  logic [WIDTH:0]   addend;
  logic [WIDTH+1:0] carry;

  assign addend = ~{1'b0, divisor};

  always_comb begin
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;  // the +1 of the two's complement
    for (int i = 0; i <= int'(WIDTH); i++) begin
      diff[i]      = trial[i] ^ addend[i] ^ carry[i];
      carry[i + 1] = (trial[i] & addend[i]) | (carry[i] & (trial[i] ^ addend[i]));
    end
  end

  assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring integer divider: one quotient bit per clock.
// Build option: define DIV_SIGNED_EN for two's-complement operands (magnitudes go
// through the unsigned core, signs are applied when the result is loaded).
//   i_clk        in  1      clock, rising edge
//   i_rst_n      in  1      asynchronous active-low reset
//   i_start      in  1      start request (accepted in idle or in the result cycle)
//   i_dividend   in  WIDTH  dividend, sampled with i_start
//   i_divisor    in  WIDTH  divisor, sampled with i_start
//   o_busy       out 1      high while iterating
//   o_done       out 1      one-cycle pulse, results valid from this cycle
//   o_quotient   out WIDTH  quotient, held until the next result load
//   o_remainder  out WIDTH  remainder, held until the next result load
//   o_div_zero   out 1      divide-by-zero flag of the last operation
module divider_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidthDefault
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int unsigned     CntW    = div_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;

  // The partial remainder never exceeds the divisor, so its top bit stays 0.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_sub_step #(
    .WIDTH(WIDTH)
  ) u_sub_step (
    .trial  (trial),
    .divisor(dvs_q),
    .diff   (diff),
    .borrow (borrow)
  );

  assign step_r = borrow ? trial : diff;
  assign step_q = {q_q[WIDTH-2:0], ~borrow};

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign op_dividend = i_dividend[WIDTH-1] ? (~i_dividend + One) : i_dividend;
  assign op_divisor  = i_divisor[WIDTH-1]  ? (~i_divisor + One)  : i_divisor;
  // Most-negative / -1 wraps naturally: magnitude 2^(W-1) negates to itself.
  assign quo_fix = qneg_q ? (~step_q + One) : step_q;
  assign rem_fix = rneg_q ? (~step_r[WIDTH-1:0] + One) : step_r[WIDTH-1:0];
`else
  assign op_dividend = i_dividend;
  assign op_divisor  = i_divisor;
  assign quo_fix     = step_q;
  assign rem_fix     = step_r[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      StCalc: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          dz_d    = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start in the result cycle is taken like one in idle, so ops can chain.
    if (i_start && (state_q != StCalc)) begin
      if (i_divisor == '0) begin
        state_d = StDone;
        quo_d   = '1;
        rem_d   = i_dividend;
        dz_d    = 1'b1;
      end else begin
        state_d = StCalc;
        r_d     = '0;
        q_d     = op_dividend;
        dvs_d   = op_divisor;
        cnt_d   = CntInit;
`ifdef DIV_SIGNED_EN
        qneg_d  = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
        rneg_d  = i_dividend[WIDTH-1];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  assign o_busy      = (state_q == StCalc);
  assign o_done      = (state_q == StDone);
  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;
  assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_q  = '0;
  logic [W-1:0] prev_r  = '0;
  logic         prev_dz = 1'b0;

  divider_seq #(
    .WIDTH(W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_busy     (busy),
    .o_done     (done),
    .o_quotient (quotient),
    .o_remainder(remainder),
    .o_div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eq, output logic [W-1:0] er,
                       output logic edz);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      eq = '1; er = a; edz = 1'b1;
    end else if (sa == -(1 << (W - 1)) && sb == -1) begin
      eq = a; er = '0; edz = 1'b0;
    end else begin
      eq = W'(sa / sb); er = W'(sa % sb); edz = 1'b0;
    end
`else
    if (b == 0) begin
      eq = '1; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
`endif
  endtask

  // Called #1 after a clock edge; start is sampled on the following edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Waits for done after an issue; returns in the done cycle.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
    int busy_n = 0;
    int done_n = 0;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    model(a, b, eq, er, edz);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (n == inject_at) begin
        start = 1'b1; dividend = 4'd6; divisor = 4'd3;
      end
      if (n == inject_at + 1) start = 1'b0;
      if (n == 1 && b != 0) begin
        check("hold_q_in_calc", quotient, prev_q);
        check("hold_r_in_calc", remainder, prev_r);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n = n;
        break;
      end
    end
    check("done_latency", done_n, (b == 0) ? 1 : W + 1);
    check("busy_cycles", busy_n, (b == 0) ? 0 : W);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
  endtask

  task automatic tail();
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("held_q", quotient, prev_q);
    check("held_r", remainder, prev_r);
  endtask

  initial begin
    int extra_done;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifndef DIV_SIGNED_EN
    logic [2*W-1:0] recon;
`endif
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_dz", div_zero, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd13, 4'd3);
    collect(4'd13, 4'd3, 0);
`ifndef DIV_SIGNED_EN
    check("q_13_3", quotient, 4'd4);
    check("r_13_3", remainder, 4'd1);
`endif
    tail();

    issue(4'd7, 4'd0);
    collect(4'd7, 4'd0, 0);
    check("q_7_0", quotient, 4'hF);
    check("r_7_0", remainder, 4'd7);
    tail();

    // Back-to-back: next start held in the done cycle.
    issue(4'd3, 4'd5);
    collect(4'd3, 4'd5, 0);
    issue(4'd15, 4'd1);
    collect(4'd15, 4'd1, 0);
    tail();

    // Start pulsed mid-iteration must be ignored.
    issue(4'd9, 4'd2);
    collect(4'd9, 4'd2, 2);
`ifndef DIV_SIGNED_EN
    check("q_9_2", quotient, 4'd4);
    check("r_9_2", remainder, 4'd1);
`endif
    tail();
    extra_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("no_second_done", extra_done, 0);

    // Reset in the middle of an operation.
    issue(4'd14, 4'd3);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, '0);
    check("midrst_r", remainder, '0);
    check("midrst_dz", div_zero, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    extra_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    check("midrst_quiet", extra_done, 0);
    issue(4'd14, 4'd3);
    collect(4'd14, 4'd3, 0);
`ifndef DIV_SIGNED_EN
    check("q_14_3", quotient, 4'd4);
    check("r_14_3", remainder, 4'd2);
`endif
    tail();

`ifdef DIV_SIGNED_EN
    issue(4'b1001, 4'd2);
    collect(4'b1001, 4'd2, 0);
    check("sq_m7_2", quotient, 4'b1101);
    check("sr_m7_2", remainder, 4'b1111);
    tail();
    issue(4'b1000, 4'b1111);
    collect(4'b1000, 4'b1111, 0);
    check("sq_m8_m1", quotient, 4'b1000);
    check("sr_m8_m1", remainder, 4'b0000);
    check("sdz_m8_m1", div_zero, 1'b0);
    tail();
`endif

    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(a, b);
      collect(a, b, 0);
`ifndef DIV_SIGNED_EN
      if (b != 0) begin
        recon = quotient * b + remainder;
        check("invariant_sum", recon, {{W{1'b0}}, a});
        check("invariant_rem_lt", remainder < b, 1'b1);
      end
`endif
      tail();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
